// File: rtl/onchip_ram_2p.sv
// Two-port Avalon-MM on-chip RAM: both slave ports share one single-port memory
// through a round-robin arbiter, with pipelined reads tagged by the requesting port.
module onchip_ram_2p #(
  parameter int    DATA_WIDTH = 32,
  parameter int    ADDR_WIDTH = 10,
  parameter int    OUT_REG    = 0,
  parameter string INIT_FILE  = ""
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    clken,
  input  logic                    reset_req,

  input  logic [ADDR_WIDTH-1:0]   s1_address,
  input  logic [DATA_WIDTH/8-1:0] s1_byteenable,
  input  logic                    s1_chipselect,
  input  logic                    s1_read,
  input  logic                    s1_write,
  input  logic [DATA_WIDTH-1:0]   s1_writedata,
  output logic [DATA_WIDTH-1:0]   s1_readdata,
  output logic                    s1_readdatavalid,
  output logic                    s1_waitrequest,

  input  logic [ADDR_WIDTH-1:0]   s2_address,
  input  logic [DATA_WIDTH/8-1:0] s2_byteenable,
  input  logic                    s2_chipselect,
  input  logic                    s2_read,
  input  logic                    s2_write,
  input  logic [DATA_WIDTH-1:0]   s2_writedata,
  output logic [DATA_WIDTH-1:0]   s2_readdata,
  output logic                    s2_readdatavalid,
  output logic                    s2_waitrequest
);

  localparam int BE_W  = DATA_WIDTH / 8;
  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic                  stall;
  logic                  req1, req2;
  logic                  gnt1, gnt2, gnt_any;
  logic                  gnt_wr, gnt_rd;
  logic [ADDR_WIDTH-1:0] acc_addr;
  logic [BE_W-1:0]       acc_be;
  logic [DATA_WIDTH-1:0] acc_wdata;
  logic                  acc_write;

  // last_grant: 0 = s1 granted most recently, 1 = s2
  logic                  last_grant_q, last_grant_d;
  logic                  vld_p0_q, vld_p0_d;
  logic                  tag_p0_q, tag_p0_d;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DATA_WIDTH-1:0] ram_q;

  logic                  rd_vld;
  logic                  rd_tag;
  logic [DATA_WIDTH-1:0] rd_data;

  // Arbitration: one grant per cycle, ties go to the port not served last time
  always_comb begin
    stall = ~clken | reset_req | reset;
    req1  = s1_chipselect & (s1_read | s1_write);
    req2  = s2_chipselect & (s2_read | s2_write);
    gnt1  = 1'b0;
    gnt2  = 1'b0;
    if (!stall) begin
      if (req1 && req2) begin
        gnt1 = last_grant_q;
        gnt2 = ~last_grant_q;
      end else begin
        gnt1 = req1;
        gnt2 = req2;
      end
    end
    gnt_any      = gnt1 | gnt2;
    acc_addr     = gnt2 ? s2_address    : s1_address;
    acc_be       = gnt2 ? s2_byteenable : s1_byteenable;
    acc_wdata    = gnt2 ? s2_writedata  : s1_writedata;
    acc_write    = gnt2 ? s2_write      : s1_write;
    gnt_wr       = gnt_any & acc_write;
    gnt_rd       = gnt_any & ~acc_write;
    last_grant_d = gnt_any ? gnt2 : last_grant_q;
    vld_p0_d     = stall ? vld_p0_q : gnt_rd;
    tag_p0_d     = stall ? tag_p0_q : gnt2;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      last_grant_q <= 1'b1;
      vld_p0_q     <= 1'b0;
    end else begin
      last_grant_q <= last_grant_d;
      vld_p0_q     <= vld_p0_d;
    end
  end

  always_ff @(posedge clk) begin
    tag_p0_q <= tag_p0_d;
  end

  // Stage p0 boundary: memory access, reads and writes never share a cycle
  always_ff @(posedge clk) begin
    if (gnt_wr) begin
      for (int b = 0; b < BE_W; b++) begin
        if (acc_be[b]) mem[acc_addr][b*8 +: 8] <= acc_wdata[b*8 +: 8];
      end
    end else if (gnt_rd) begin
      ram_q <= mem[acc_addr];
    end
  end

  if (OUT_REG != 0) begin : g_out_reg
    logic                  vld_p1_q, vld_p1_d;
    logic                  tag_p1_q, tag_p1_d;
    logic [DATA_WIDTH-1:0] dout_p1_q, dout_p1_d;

    always_comb begin
      vld_p1_d  = stall ? vld_p1_q  : vld_p0_q;
      tag_p1_d  = stall ? tag_p1_q  : tag_p0_q;
      dout_p1_d = stall ? dout_p1_q : ram_q;
    end

    // Stage p1 boundary: optional output register
    always_ff @(posedge clk) begin
      if (reset) vld_p1_q <= 1'b0;
      else       vld_p1_q <= vld_p1_d;
    end

    always_ff @(posedge clk) begin
      tag_p1_q  <= tag_p1_d;
      dout_p1_q <= dout_p1_d;
    end

    assign rd_vld  = vld_p1_q;
    assign rd_tag  = tag_p1_q;
    assign rd_data = dout_p1_q;
  end else begin : g_no_out_reg
    assign rd_vld  = vld_p0_q;
    assign rd_tag  = tag_p0_q;
    assign rd_data = ram_q;
  end

  always_comb begin
    s1_waitrequest   = req1 & ~gnt1;
    s2_waitrequest   = req2 & ~gnt2;
    s1_readdatavalid = rd_vld & ~stall & ~rd_tag;
    s2_readdatavalid = rd_vld & ~stall &  rd_tag;
    s1_readdata      = s1_readdatavalid ? rd_data : '0;
    s2_readdata      = s2_readdatavalid ? rd_data : '0;
  end

endmodule

// File: tb/tb_onchip_ram_2p.sv
// Bench for onchip_ram_2p: drives one instance per read latency with the same
// stimulus and compares both against a cycle-level behavioural model.
module tb_onchip_ram_2p;

  logic clk;
  logic reset, clken, reset_req;

  logic [9:0]  addr_i [2];
  logic [3:0]  be_i   [2];
  logic        cs_i   [2];
  logic        rd_i   [2];
  logic        wr_i   [2];
  logic [31:0] wd_i   [2];

  logic [31:0] rd_o   [2][2];
  logic        vld_o  [2][2];
  logic        wt_o   [2][2];

  int n_chk  = 0;
  int n_fail = 0;

  // Bench-side observations used by the literal checks
  int          n_vld   [2][2];
  logic [31:0] last_rd [2][2];

  // Behavioural model state
  logic [31:0] mem_m [1024];
  int          last_m;
  bit          e_vld  [2][4];
  int          e_port [2][4];
  int          e_cnt  [2][4];
  logic [31:0] e_data [2][4];

  for (genvar g = 0; g < 2; g++) begin : g_dut
    onchip_ram_2p #(
      .DATA_WIDTH(32), .ADDR_WIDTH(10), .OUT_REG(g), .INIT_FILE("")
    ) u_dut (
      .clk(clk), .reset(reset), .clken(clken), .reset_req(reset_req),
      .s1_address(addr_i[0]), .s1_byteenable(be_i[0]), .s1_chipselect(cs_i[0]),
      .s1_read(rd_i[0]), .s1_write(wr_i[0]), .s1_writedata(wd_i[0]),
      .s1_readdata(rd_o[g][0]), .s1_readdatavalid(vld_o[g][0]),
      .s1_waitrequest(wt_o[g][0]),
      .s2_address(addr_i[1]), .s2_byteenable(be_i[1]), .s2_chipselect(cs_i[1]),
      .s2_read(rd_i[1]), .s2_write(wr_i[1]), .s2_writedata(wd_i[1]),
      .s2_readdata(rd_o[g][1]), .s2_readdatavalid(vld_o[g][1]),
      .s2_waitrequest(wt_o[g][1])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // Model: a read returns on the L-th non-stalled cycle after its grant (L = 1 + OUT_REG)
  always @(negedge clk) begin : cmp
    bit          stall;
    bit          req [2];
    int          gnt;
    bit          exp_vld;
    logic [31:0] exp_data;
    bit          placed;
    stall  = !clken || reset_req || reset;
    req[0] = cs_i[0] && (rd_i[0] || wr_i[0]);
    req[1] = cs_i[1] && (rd_i[1] || wr_i[1]);
    gnt = -1;
    if (!stall) begin
      if (req[0] && req[1]) gnt = (last_m == 1) ? 0 : 1;
      else if (req[0])      gnt = 0;
      else if (req[1])      gnt = 1;
    end
    for (int d = 0; d < 2; d++) begin
      for (int p = 0; p < 2; p++) begin
        exp_vld  = 1'b0;
        exp_data = 32'h0;
        for (int k = 0; k < 4; k++) begin
          if (e_vld[d][k] && e_cnt[d][k] == 1 && e_port[d][k] == p && !stall) begin
            exp_vld  = 1'b1;
            exp_data = e_data[d][k];
          end
        end
        chk($sformatf("d%0d_s%0d_waitrequest", d, p + 1), 32'(wt_o[d][p]),
            32'(req[p] && gnt != p));
        chk($sformatf("d%0d_s%0d_readdatavalid", d, p + 1), 32'(vld_o[d][p]), 32'(exp_vld));
        chk($sformatf("d%0d_s%0d_readdata", d, p + 1), rd_o[d][p], exp_data);
        if (vld_o[d][p]) begin
          n_vld[d][p]++;
          last_rd[d][p] = rd_o[d][p];
        end
      end
    end
    if (reset) begin
      last_m = 1;
      for (int d = 0; d < 2; d++) for (int k = 0; k < 4; k++) e_vld[d][k] = 1'b0;
    end else if (!stall) begin
      for (int d = 0; d < 2; d++) begin
        for (int k = 0; k < 4; k++) begin
          if (e_vld[d][k]) begin
            if (e_cnt[d][k] == 1) e_vld[d][k] = 1'b0;
            else                  e_cnt[d][k]--;
          end
        end
      end
      if (gnt >= 0) begin
        if (wr_i[gnt]) begin
          for (int b = 0; b < 4; b++)
            if (be_i[gnt][b]) mem_m[addr_i[gnt]][b*8 +: 8] = wd_i[gnt][b*8 +: 8];
        end else begin
          for (int d = 0; d < 2; d++) begin
            placed = 1'b0;
            for (int k = 0; k < 4; k++) begin
              if (!e_vld[d][k] && !placed) begin
                e_vld[d][k]  = 1'b1;
                e_port[d][k] = gnt;
                e_cnt[d][k]  = d + 1;
                e_data[d][k] = mem_m[addr_i[gnt]];
                placed       = 1'b1;
              end
            end
          end
        end
        last_m = gnt;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    for (int p = 0; p < 2; p++) begin
      addr_i[p] = '0; be_i[p] = '0; cs_i[p] = 1'b0;
      rd_i[p] = 1'b0; wr_i[p] = 1'b0; wd_i[p] = '0;
    end
  endtask

  task automatic drv(input int p, input bit w, input logic [9:0] a,
                     input logic [31:0] d, input logic [3:0] be);
    addr_i[p] = a; be_i[p] = be; cs_i[p] = 1'b1;
    rd_i[p] = !w; wr_i[p] = w; wd_i[p] = d;
  endtask

  task automatic clr_cnt();
    for (int d = 0; d < 2; d++) for (int p = 0; p < 2; p++) n_vld[d][p] = 0;
  endtask

  initial begin
    last_m = 1;
    for (int d = 0; d < 2; d++) for (int k = 0; k < 4; k++) e_vld[d][k] = 1'b0;
    clr_cnt();
    idle();
    reset = 1'b1; clken = 1'b1; reset_req = 1'b0;

    // Requester during reset sees waitrequest, outputs quiet
    drv(0, 1'b0, 10'h000, 32'h0, 4'hF);
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("rst_d%0d_wait", d), 32'(wt_o[d][0]), 32'd1);
      chk($sformatf("rst_d%0d_vld", d), 32'(vld_o[d][0]), 32'd0);
      chk($sformatf("rst_d%0d_rdata", d), rd_o[d][0], 32'h0);
    end
    tick(); tick();
    reset = 1'b0;
    idle();
    tick();

    // Single-port write then read at the top address
    drv(0, 1'b1, 10'h3FF, 32'hDEADBEEF, 4'hF);
    @(negedge clk); chk("sp_wr_wait", 32'(wt_o[0][0]), 32'd0);
    tick();
    drv(0, 1'b0, 10'h3FF, 32'h0, 4'hF);
    @(negedge clk); chk("sp_rd_wait", 32'(wt_o[0][0]), 32'd0);
    tick();
    idle();
    @(negedge clk);
    chk("sp_d0_vld_t1", 32'(vld_o[0][0]), 32'd1);
    chk("sp_d0_data_t1", rd_o[0][0], 32'hDEADBEEF);
    chk("sp_d1_vld_t1", 32'(vld_o[1][0]), 32'd0);
    tick();
    @(negedge clk);
    chk("sp_d1_vld_t2", 32'(vld_o[1][0]), 32'd1);
    chk("sp_d1_data_t2", rd_o[1][0], 32'hDEADBEEF);
    tick();

    // Byte lanes
    drv(0, 1'b1, 10'h010, 32'h11223344, 4'hF); tick();
    drv(0, 1'b1, 10'h010, 32'hAABBCCDD, 4'h5); tick();
    drv(0, 1'b0, 10'h010, 32'h0, 4'hF);        tick();
    idle(); tick(); tick(); tick();
    chk("be_d0_data", last_rd[0][0], 32'h11BB33DD);
    chk("be_d1_data", last_rd[1][0], 32'h11BB33DD);

    // Contention after reset: s1 first, then strict alternation
    reset = 1'b1; tick(); reset = 1'b0;
    clr_cnt();
    drv(0, 1'b0, 10'h3FF, 32'h0, 4'hF);
    drv(1, 1'b0, 10'h010, 32'h0, 4'hF);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk($sformatf("ct_s1_wait_%0d", i), 32'(wt_o[0][0]), 32'(i % 2 == 1));
      chk($sformatf("ct_s2_wait_%0d", i), 32'(wt_o[0][1]), 32'(i % 2 == 0));
      tick();
    end
    idle(); tick(); tick(); tick();
    for (int d = 0; d < 2; d++) for (int p = 0; p < 2; p++)
      chk($sformatf("ct_d%0d_s%0d_pulses", d, p + 1), 32'(n_vld[d][p]), 32'd3);
    chk("ct_d1_s1_data", last_rd[1][0], 32'hDEADBEEF);
    chk("ct_d1_s2_data", last_rd[1][1], 32'h11BB33DD);

    // Coherence, s2 wins the tie because s1 was granted last
    drv(0, 1'b1, 10'h005, 32'hA5A5A5A5, 4'hF); tick();
    drv(0, 1'b0, 10'h005, 32'h0, 4'hF);
    drv(1, 1'b1, 10'h005, 32'h12345678, 4'hF);
    @(negedge clk);
    chk("coh1_s1_wait", 32'(wt_o[0][0]), 32'd1);
    chk("coh1_s2_wait", 32'(wt_o[0][1]), 32'd0);
    tick();
    idle(); drv(0, 1'b0, 10'h005, 32'h0, 4'hF);
    @(negedge clk); chk("coh1_s1_wait2", 32'(wt_o[0][0]), 32'd0);
    tick();
    idle(); tick(); tick(); tick();
    chk("coh1_d0_data", last_rd[0][0], 32'h12345678);
    chk("coh1_d1_data", last_rd[1][0], 32'h12345678);

    // Coherence, s1 wins the tie because s2 was granted last: old data returned
    drv(1, 1'b1, 10'h006, 32'h0, 4'hF); tick();
    idle();
    drv(0, 1'b0, 10'h005, 32'h0, 4'hF);
    drv(1, 1'b1, 10'h005, 32'hCAFEF00D, 4'hF);
    @(negedge clk);
    chk("coh2_s1_wait", 32'(wt_o[0][0]), 32'd0);
    chk("coh2_s2_wait", 32'(wt_o[0][1]), 32'd1);
    tick();
    idle(); drv(1, 1'b1, 10'h005, 32'hCAFEF00D, 4'hF); tick();
    idle(); tick(); tick(); tick();
    chk("coh2_d0_old", last_rd[0][0], 32'h12345678);
    chk("coh2_d1_old", last_rd[1][0], 32'h12345678);
    drv(0, 1'b0, 10'h005, 32'h0, 4'hF); tick();
    idle(); tick(); tick(); tick();
    chk("coh2_d0_new", last_rd[0][0], 32'hCAFEF00D);
    chk("coh2_d1_new", last_rd[1][0], 32'hCAFEF00D);

    // Stall with clken low, then with reset_req high
    for (int m = 0; m < 2; m++) begin
      clr_cnt();
      drv(0, 1'b0, 10'h3FF, 32'h0, 4'hF); tick();
      idle();
      if (m == 0) clken = 1'b0; else reset_req = 1'b1;
      for (int i = 0; i < 3; i++) begin
        @(negedge clk);
        chk($sformatf("st%0d_d0_vld_%0d", m, i), 32'(vld_o[0][0]), 32'd0);
        chk($sformatf("st%0d_d1_vld_%0d", m, i), 32'(vld_o[1][0]), 32'd0);
        tick();
      end
      clken = 1'b1; reset_req = 1'b0;
      @(negedge clk);
      chk($sformatf("st%0d_d0_vld_after", m), 32'(vld_o[0][0]), 32'd1);
      chk($sformatf("st%0d_d1_vld_after1", m), 32'(vld_o[1][0]), 32'd0);
      tick();
      @(negedge clk);
      chk($sformatf("st%0d_d1_vld_after2", m), 32'(vld_o[1][0]), 32'd1);
      chk($sformatf("st%0d_d1_data", m), rd_o[1][0], 32'hDEADBEEF);
      tick(); tick();
      chk($sformatf("st%0d_d0_pulses", m), 32'(n_vld[0][0]), 32'd1);
      chk($sformatf("st%0d_d1_pulses", m), 32'(n_vld[1][0]), 32'd1);
    end

    // Reset in the cycle after a read grant drops that read
    clr_cnt();
    drv(0, 1'b0, 10'h010, 32'h0, 4'hF); tick();
    idle(); reset = 1'b1;
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("rr_d%0d_vld", d), 32'(vld_o[d][0]), 32'd0);
      chk($sformatf("rr_d%0d_s1_rdata", d), rd_o[d][0], 32'h0);
      chk($sformatf("rr_d%0d_s2_rdata", d), rd_o[d][1], 32'h0);
    end
    tick();
    reset = 1'b0;
    tick(); tick(); tick();
    chk("rr_d0_pulses", 32'(n_vld[0][0]), 32'd0);
    chk("rr_d1_pulses", 32'(n_vld[1][0]), 32'd0);
    drv(0, 1'b0, 10'h010, 32'h0, 4'hF); tick();
    idle(); tick(); tick(); tick();
    chk("rr_d0_mem_kept", last_rd[0][0], 32'h11BB33DD);
    chk("rr_d1_mem_kept", last_rd[1][0], 32'h11BB33DD);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/onchip_ram_2p.md
# onchip_ram_2p

Parametrised Avalon-MM on-chip RAM with two slave ports, s1 and s2, that share one single-port inferred memory. It extends the 32-bit by 1024-word single-port data memory with:
- configurable width, depth and read latency
- round-robin arbitration between the two ports
- per-port `waitrequest` / `readdatavalid` pipelined-read handshaking

It sits on the Qsys interconnect as a data or scratch memory that the CPU and a DMA master reach at the same time.

## Interface

Parameters:
- `DATA_WIDTH`, 32: word width in bits; multiple of 8.
- `ADDR_WIDTH`, 10: word address width; depth is 2^ADDR_WIDTH.
- `OUT_REG`, 0: 0 gives 1-cycle read latency; 1 adds an output register and gives 2-cycle read latency.
- `INIT_FILE`, "": memory init file; empty means no initialisation.

Ports (the `sN_` prefix means one copy per port, N = 1, 2):
- `clk`  in  1  sole clock; all logic on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `clken`  in  1  global clock enable; low stalls the block.
- `reset_req`  in  1  high stalls the block and protects RAM contents during reset sequencing.
- `sN_address`  in  ADDR_WIDTH  word address.
- `sN_byteenable`  in  DATA_WIDTH/8  byte-lane write enables.
- `sN_chipselect`  in  1  port selected.
- `sN_read`  in  1  read request.
- `sN_write`  in  1  write request.
- `sN_writedata`  in  DATA_WIDTH  write data.
- `sN_readdata`  out  DATA_WIDTH  read data; forced to 0 whenever `sN_readdatavalid` is 0.
- `sN_readdatavalid`  out  1  one-cycle pulse marking returned read data.
- `sN_waitrequest`  out  1  request not accepted this cycle.

## Operation

- Request definition: `reqN = sN_chipselect & (sN_read | sN_write)`.
  - If read and write are both high, the request is treated as a write.
- Stall condition: `stall = ~clken | reset_req | reset`.
- Grant rules, at most one grant per cycle, none while stalled:
  - Only one port requesting: that port is granted.
  - Both ports requesting: the port not granted last time wins.
  - The `last_grant` register updates only on a cycle with a grant.
- `sN_waitrequest = reqN & ~grantN`, so it is combinational.
  - It is 0 when the port is not requesting.
  - A granted request is accepted in that cycle.
- Write: on the grant edge, each byte lane with its `byteenable` bit high is written. A write with `byteenable` = 0 is granted and leaves memory unchanged.
- Read: the granted port's ID enters a valid/tag pipeline of depth 1 + `OUT_REG`. When the entry exits, the matching `sN_readdatavalid` pulses with the data.
- Ordering:
  - Accesses are strictly serialised, so a read granted after a write to the same address (either port) returns the new data.
  - There is no same-cycle read/write hazard.
- Stall behaviour:
  - The RAM clock enable, the output register and the tag pipeline all hold.
  - `readdatavalid` is gated to 0.
  - A pending read returns in the first non-stalled cycle in which its stage would have exited.
- Reset (synchronous):
  - Clears the tag pipeline, so in-flight reads are dropped with no `readdatavalid`.
  - Sets `last_grant` to s2, so s1 wins the first tie.
  - Does not clear memory contents.

## Timing

- Reset values of outputs:
  - `sN_readdatavalid` = 0.
  - `sN_readdata` = 0.
  - `sN_waitrequest` = `reqN`, i.e. high for any requester while `reset` is high.
- Read latency from the grant edge (counted on non-stalled cycles only):
  - `OUT_REG`=0: `readdatavalid` is high in cycle T+1 for a read granted in cycle T.
  - `OUT_REG`=1: `readdatavalid` is high in cycle T+2.
- Throughput: one access per cycle in aggregate. Under continuous contention each port gets one access every 2 cycles.
- Write latency: memory is updated at the grant edge. A read granted in the next cycle sees the new data.
- Address wrap: the address is exactly ADDR_WIDTH bits, so there is no wrap logic. The top address 2^ADDR_WIDTH-1 is valid.

## Test plan

- Single port R/W:
  - Stimulus: s1 writes 0xDEADBEEF to addr 0x3FF with byteenable 0xF, then reads addr 0x3FF.
  - Required response: no waitrequest; `s1_readdatavalid` goes high 1 cycle after the read grant (`OUT_REG`=0), with readdata 0xDEADBEEF.
- Byte lanes:
  - Stimulus: write 0x11223344 with byteenable 0xF, then 0xAABBCCDD with byteenable 0x5, then read.
  - Required response: readdata 0x11BB33DD.
- Contention:
  - Stimulus: after reset, s1 and s2 both read continuously for 6 cycles.
  - Required response: grants alternate s1, s2, s1, and so on. Each waitrequest is high on alternate cycles. Each port receives 3 readdatavalid pulses, with no pulse on the other port's lines.
- Cross-port coherence:
  - Stimulus: s2 writes 0x12345678 to addr 5 while s1 reads addr 5 in the same cycle.
  - Required response: s2 wins the tie only if `last_grant` = s1, and s1's read then returns 0x12345678. If s1 is granted first, s1 returns the old value.
- Stall:
  - Stimulus: `OUT_REG`=1, s1 read granted, then `clken` low for 3 cycles.
  - Required response: no readdatavalid during the stall; the pulse appears 1 non-stalled cycle after the stall ends, carrying the correct data. `reset_req` high gives the same result.
- Reset mid-read:
  - Stimulus: `reset` asserted in the cycle after a read grant, held for 1 cycle.
  - Required response: no readdatavalid for that read; both readdata outputs are 0; memory contents are unchanged on a subsequent read.
